// File: rtl/rgen_access_initiator.sv
// Host-side initiator for the register block's internal access bus: one command in,
// one single-cycle strobe to the decoders, one response with an OK/NO_HIT/MULTI_HIT status.
module rgen_access_initiator #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 32,
    parameter int REGISTERS     = 4
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_command_valid,
    output logic                            o_command_ready,
    input  logic [ADDRESS_WIDTH-1:0]        i_command_address,
    input  logic                            i_command_write,
    input  logic [DATA_WIDTH-1:0]           i_command_write_data,
    output logic                            o_response_valid,
    input  logic                            i_response_ready,
    output logic [DATA_WIDTH-1:0]           o_response_read_data,
    output logic [1:0]                      o_response_status,
    output logic [ADDRESS_WIDTH-1:0]        o_address,
    output logic                            o_read,
    output logic                            o_write,
    output logic [DATA_WIDTH-1:0]           o_write_data,
    input  logic [REGISTERS-1:0]            i_select,
    input  logic [REGISTERS*DATA_WIDTH-1:0] i_read_data
);

    localparam logic [1:0] STATUS_OK        = 2'b00;
    localparam logic [1:0] STATUS_NO_HIT    = 2'b10;
    localparam logic [1:0] STATUS_MULTI_HIT = 2'b11;

    typedef enum logic [1:0] {IDLE, ACCESS, RESPONSE} state_t;

    state_t                   state_q;
    logic                     cmd_ready_q;
    logic                     read_q;
    logic                     write_q;
    logic [ADDRESS_WIDTH-1:0] address_q;
    logic [DATA_WIDTH-1:0]    wdata_q;
    logic                     resp_valid_q;
    logic [DATA_WIDTH-1:0]    resp_data_q;
    logic [1:0]               resp_status_q;

    logic                     any_hit;
    logic                     multi_hit;
    logic [DATA_WIDTH-1:0]    hit_data;
    logic [DATA_WIDTH-1:0]    resp_data_d;
    logic [1:0]               resp_status_d;

    // OR of selected words equals the selected word whenever exactly one decoder hits.
    always_comb begin
        any_hit   = 1'b0;
        multi_hit = 1'b0;
        hit_data  = '0;
        for (int k = 0; k < REGISTERS; k++) begin
            if (i_select[k]) begin
                multi_hit = multi_hit | any_hit;
                any_hit   = 1'b1;
                hit_data  = hit_data | i_read_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        resp_data_d   = '0;
        resp_status_d = STATUS_OK;
        if (!any_hit) begin
            resp_status_d = STATUS_NO_HIT;
        end else if (multi_hit) begin
            resp_status_d = STATUS_MULTI_HIT;
        end else if (!write_q) begin
            resp_data_d = hit_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= IDLE;
            cmd_ready_q   <= 1'b1;
            read_q        <= 1'b0;
            write_q       <= 1'b0;
            address_q     <= '0;
            wdata_q       <= '0;
            resp_valid_q  <= 1'b0;
            resp_data_q   <= '0;
            resp_status_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_command_valid && cmd_ready_q) begin
                        address_q   <= i_command_address;
                        wdata_q     <= i_command_write_data;
                        read_q      <= !i_command_write;
                        write_q     <= i_command_write;
                        cmd_ready_q <= 1'b0;
                        state_q     <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Decoders are combinational, so their answer is sampled in the strobe cycle.
                    read_q        <= 1'b0;
                    write_q       <= 1'b0;
                    resp_valid_q  <= 1'b1;
                    resp_data_q   <= resp_data_d;
                    resp_status_q <= resp_status_d;
                    state_q       <= RESPONSE;
                end
                RESPONSE: begin
                    if (i_response_ready) begin
                        resp_valid_q  <= 1'b0;
                        resp_data_q   <= '0;
                        resp_status_q <= '0;
                        cmd_ready_q   <= 1'b1;
                        state_q       <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    cmd_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign o_command_ready      = cmd_ready_q;
    assign o_response_valid     = resp_valid_q;
    assign o_response_read_data = resp_data_q;
    assign o_response_status    = resp_status_q;
    assign o_address            = address_q;
    assign o_read               = read_q;
    assign o_write              = write_q;
    assign o_write_data         = wdata_q;

endmodule

// File: tb/tb_rgen_access_initiator.sv
// Directed and randomized bench for rgen_access_initiator against a transaction-level model.
module tb_rgen_access_initiator;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int R  = 4;

    logic            i_clk = 1'b0;
    logic            i_rst;
    logic            i_command_valid;
    logic            o_command_ready;
    logic [AW-1:0]   i_command_address;
    logic            i_command_write;
    logic [DW-1:0]   i_command_write_data;
    logic            o_response_valid;
    logic            i_response_ready;
    logic [DW-1:0]   o_response_read_data;
    logic [1:0]      o_response_status;
    logic [AW-1:0]   o_address;
    logic            o_read;
    logic            o_write;
    logic [DW-1:0]   o_write_data;
    logic [R-1:0]    i_select;
    logic [R*DW-1:0] i_read_data;

    int checks = 0;
    int errors = 0;

    always #5 i_clk = ~i_clk;

    rgen_access_initiator #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .REGISTERS(R)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_command_valid(i_command_valid), .o_command_ready(o_command_ready),
        .i_command_address(i_command_address), .i_command_write(i_command_write),
        .i_command_write_data(i_command_write_data),
        .o_response_valid(o_response_valid), .i_response_ready(i_response_ready),
        .o_response_read_data(o_response_read_data), .o_response_status(o_response_status),
        .o_address(o_address), .o_read(o_read), .o_write(o_write), .o_write_data(o_write_data),
        .i_select(i_select), .i_read_data(i_read_data)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: count hits, then pick status and data from the count.
    task automatic model(input logic [R-1:0] sel, input logic [R*DW-1:0] rd, input logic wr,
                         output logic [1:0] st, output logic [DW-1:0] data);
        int n;
        int idx;
        n = 0;
        idx = 0;
        for (int k = 0; k < R; k++) if (sel[k]) begin n++; idx = k; end
        data = '0;
        if (n == 0) st = 2'b10;
        else if (n > 1) st = 2'b11;
        else begin
            st = 2'b00;
            if (!wr) data = rd[idx*DW +: DW];
        end
    endtask

    // Called just after a negedge; returns just after a negedge with the DUT back in IDLE.
    task automatic txn(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] wd,
                       input logic [R-1:0] sel, input logic [R*DW-1:0] rd,
                       input int hold, input logic push_during_hold);
        logic [1:0]    es;
        logic [DW-1:0] ed;
        int            n;
        model(sel, rd, w, es, ed);
        n = 0;
        while (!o_command_ready && n < 20) begin @(negedge i_clk); n++; end
        if (n == 20) chk("ready_timeout", 64'(o_command_ready), 64'd1);
        i_command_valid      = 1'b1;
        i_command_address    = a;
        i_command_write      = w;
        i_command_write_data = wd;
        i_select             = sel;
        i_read_data          = rd;
        @(posedge i_clk);
        #1;
        i_command_valid   = 1'b0;
        i_command_address = AW'($urandom);
        @(negedge i_clk);
        chk("strobe_read",  64'(o_read),  64'(!w));
        chk("strobe_write", 64'(o_write), 64'(w));
        chk("bus_address",  64'(o_address), 64'(a));
        chk("bus_wdata",    64'(o_write_data), 64'(wd));
        chk("ready_in_access", 64'(o_command_ready), 64'd0);
        chk("valid_in_access", 64'(o_response_valid), 64'd0);
        @(negedge i_clk);
        // Decoder inputs change after sampling; the response must not follow them.
        i_select    = R'($urandom);
        i_read_data = {$urandom, $urandom, $urandom, $urandom};
        chk("resp_valid",  64'(o_response_valid), 64'd1);
        chk("resp_status", 64'(o_response_status), 64'(es));
        chk("resp_data",   64'(o_response_read_data), 64'(ed));
        chk("no_strobe_resp", 64'({o_read, o_write}), 64'd0);
        if (push_during_hold) begin
            i_command_valid   = 1'b1;
            i_command_address = a ^ 16'h00FF;
            i_command_write   = !w;
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge i_clk);
            chk("hold_valid",  64'(o_response_valid), 64'd1);
            chk("hold_status", 64'(o_response_status), 64'(es));
            chk("hold_data",   64'(o_response_read_data), 64'(ed));
            chk("hold_ready",  64'(o_command_ready), 64'd0);
            chk("hold_strobe", 64'({o_read, o_write}), 64'd0);
        end
        i_response_ready = 1'b1;
        @(posedge i_clk);
        #1;
        i_response_ready = 1'b0;
        i_command_valid  = 1'b0;
        @(negedge i_clk);
        chk("post_valid",  64'(o_response_valid), 64'd0);
        chk("post_ready",  64'(o_command_ready), 64'd1);
        chk("post_strobe", 64'({o_read, o_write}), 64'd0);
        chk("addr_held",   64'(o_address), 64'(a));
    endtask

    initial begin
        logic [R*DW-1:0] rd;
        i_rst                = 1'b1;
        i_command_valid      = 1'b0;
        i_command_address    = '0;
        i_command_write      = 1'b0;
        i_command_write_data = '0;
        i_response_ready     = 1'b0;
        i_select             = '0;
        i_read_data          = '0;
        repeat (3) @(posedge i_clk);
        #1 i_rst = 1'b0;
        @(negedge i_clk);
        chk("rst_ready",  64'(o_command_ready), 64'd1);
        chk("rst_valid",  64'(o_response_valid), 64'd0);
        chk("rst_strobe", 64'({o_read, o_write}), 64'd0);
        chk("rst_addr",   64'(o_address), 64'd0);
        chk("rst_wdata",  64'(o_write_data), 64'd0);
        chk("rst_status", 64'(o_response_status), 64'd0);
        chk("rst_data",   64'(o_response_read_data), 64'd0);

        rd = {32'hAAAA0003, 32'h12345678, 32'h55550001, 32'h99990000};
        txn(16'h0004, 1'b1, 32'hDEADBEEF, 4'b0010, rd, 0, 1'b0);
        txn(16'h0008, 1'b0, 32'h0,        4'b0100, rd, 0, 1'b0);
        txn(16'h00F0, 1'b0, 32'h0,        4'b0000, rd, 1, 1'b0);
        txn(16'h00F0, 1'b1, 32'hCAFEF00D, 4'b0000, rd, 0, 1'b0);
        txn(16'h0000, 1'b0, 32'h0,        4'b0011, rd, 0, 1'b0);
        txn(16'h000C, 1'b0, 32'h0,        4'b1000, rd, 10, 1'b1);
        txn(16'h0000, 1'b1, 32'h01234567, 4'b1111, rd, 2, 1'b0);

        // Reset during the strobe cycle aborts the access.
        i_command_valid      = 1'b1;
        i_command_address    = 16'h0008;
        i_command_write      = 1'b0;
        i_command_write_data = 32'h0;
        i_select             = 4'b0100;
        @(posedge i_clk);
        #1 i_command_valid = 1'b0;
        @(negedge i_clk);
        chk("abort_strobe_before", 64'(o_read), 64'd1);
        i_rst = 1'b1;
        @(posedge i_clk);
        #1 i_rst = 1'b0;
        @(negedge i_clk);
        chk("abort_valid",  64'(o_response_valid), 64'd0);
        chk("abort_strobe", 64'({o_read, o_write}), 64'd0);
        chk("abort_ready",  64'(o_command_ready), 64'd1);
        chk("abort_addr",   64'(o_address), 64'd0);
        @(negedge i_clk);
        chk("abort_no_resp", 64'(o_response_valid), 64'd0);

        for (int t = 0; t < 40; t++) begin
            rd = {$urandom, $urandom, $urandom, $urandom};
            txn(AW'($urandom), 1'($urandom), $urandom, R'($urandom_range(0, 15)), rd,
                int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
